// File: rtl/wb_stage_pipe_pkg.sv
// Shared types for the write-back stage: result select, load size and FSM state encodings.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_WORD   = 2'd0,
        LD_BYTE_S = 2'd1,
        LD_BYTE_U = 2'd2,
        LD_RSVD   = 2'd3
    } ld_size_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_COMMIT   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_pipe_if.sv
// Bundle of MEM-stage inputs, data-memory response and RF/hazard outputs of the write-back stage.
// Handshake: an instruction transfers on a rising edge where in_valid & in_ready are both 1;
// in_ready depends on stage state only, and in_valid/payload are ignored while in_ready is 0.
interface wb_stage_pipe_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_wb_sel;
    logic [1:0]            in_ld_size;
    logic                  in_byte_off;
    logic [DATA_W-1:0]     in_alu;
    logic [DATA_W-1:0]     in_link;
    logic [DATA_W-1:0]     in_imm;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_reg_we;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic                  pend_valid;
    logic [REG_ADDR_W-1:0] pend_rd;
    logic [CNT_W-1:0]      commit_cnt;
    logic                  err_spurious;
    logic [1:0]            dbg_state;

    modport slave (
        input  in_valid, in_wb_sel, in_ld_size, in_byte_off, in_alu, in_link, in_imm,
               in_rd, in_reg_we, mem_rvalid, mem_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, pend_valid, pend_rd, commit_cnt,
               err_spurious, dbg_state
    );

    modport master (
        output in_valid, in_wb_sel, in_ld_size, in_byte_off, in_alu, in_link, in_imm,
               in_rd, in_reg_we, mem_rvalid, mem_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, pend_valid, pend_rd, commit_cnt,
               err_spurious, dbg_state
    );
endinterface

// File: rtl/wb_stage_pipe_load_align.sv
// Load alignment: passes words through, extracts the low/high byte and sign- or zero-extends it.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] data_i,
    input  ld_size_e          size_i,
    input  logic              byte_off_i,
    output logic [DATA_W-1:0] data_o
);
    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = byte_off_i ? data_i[15:8] : data_i[7:0];
        data_o   = data_i;
        case (size_i)
            LD_BYTE_S: data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_BYTE_U: data_o = {{(DATA_W-8){1'b0}}, byte_sel};
            default:   data_o = data_i;
        endcase
    end
endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register with result select, load alignment and a wait state for slow reads.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
) (
    input logic             clk,
    input logic             rst_n,
    wb_stage_pipe_if.slave  bus
);
    wb_state_e             state_q, state_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    ld_size_e              size_q, size_d;
    logic                  off_q, off_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic                  in_ready;
    logic                  accept;
    wb_sel_e               sel;
    logic [DATA_W-1:0]     sel_val;
    logic [DATA_W-1:0]     aligned;

    assign sel      = wb_sel_e'(bus.in_wb_sel);
    assign in_ready = (state_q != ST_WAIT_MEM);
    assign accept   = bus.in_valid & in_ready;

    wb_load_align #(.DATA_W(DATA_W)) u_align (
        .data_i     (bus.mem_rdata),
        .size_i     (size_q),
        .byte_off_i (off_q),
        .data_o     (aligned)
    );

    always_comb begin
        sel_val = bus.in_alu;
        case (sel)
            WB_LINK: sel_val = bus.in_link;
            WB_IMM:  sel_val = bus.in_imm;
            default: sel_val = bus.in_alu;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        rd_d    = rd_q;
        size_d  = size_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    waddr_d = rd_q;
                    wdata_d = aligned;
                    state_d = ST_COMMIT;
                end
            end
            default: begin
                // IDLE and COMMIT both accept; a COMMIT cycle always retires its entry.
                if (state_q == ST_COMMIT) cnt_d = cnt_q + CNT_W'(1);
                if (bus.mem_rvalid) err_d = 1'b1;
                state_d = ST_IDLE;
                if (accept) begin
                    we_d = bus.in_reg_we;
                    if (sel == WB_MEM) begin
                        rd_d    = bus.in_rd;
                        size_d  = ld_size_e'(bus.in_ld_size);
                        off_d   = bus.in_byte_off;
                        state_d = ST_WAIT_MEM;
                    end else begin
                        waddr_d = bus.in_rd;
                        wdata_d = sel_val;
                        state_d = ST_COMMIT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            rd_q    <= '0;
            size_q  <= LD_WORD;
            off_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            size_q  <= size_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.rf_we        = (state_q == ST_COMMIT) && we_q;
    assign bus.rf_waddr     = waddr_q;
    assign bus.rf_wdata     = wdata_q;
    assign bus.pend_valid   = (state_q == ST_WAIT_MEM) && we_q;
    assign bus.pend_rd      = (state_q == ST_WAIT_MEM) ? rd_q : '0;
    assign bus.commit_cnt   = cnt_q;
    assign bus.err_spurious = err_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: vector table, hand-written corner sequences and a randomized run
// scored against a plain-arithmetic model; a CNT_W=2 copy shares the inputs for wrap checks.
module tb_wb_stage_pipe;
    import wb_pkg::*;

    localparam int W = 3 + 16;

    typedef struct {
        logic [1:0]  sel;
        logic [1:0]  size;
        logic        off;
        logic [15:0] alu;
        logic [15:0] link;
        logic [15:0] imm;
        logic [15:0] mem;
        logic [2:0]  rd;
        logic        we;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    int exp_commits = 0;
    logic sb_en = 1'b0;
    logic [W-1:0] exp_q[$];

    wb_stage_pipe_if #(.DATA_W(16), .REG_ADDR_W(3), .CNT_W(16)) bus ();
    wb_stage_pipe_if #(.DATA_W(16), .REG_ADDR_W(3), .CNT_W(2))  bus2 ();

    wb_stage_pipe #(.DATA_W(16), .REG_ADDR_W(3), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    wb_stage_pipe #(.DATA_W(16), .REG_ADDR_W(3), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus2.in_valid    = bus.in_valid;
    assign bus2.in_wb_sel   = bus.in_wb_sel;
    assign bus2.in_ld_size  = bus.in_ld_size;
    assign bus2.in_byte_off = bus.in_byte_off;
    assign bus2.in_alu      = bus.in_alu;
    assign bus2.in_link     = bus.in_link;
    assign bus2.in_imm      = bus.in_imm;
    assign bus2.in_rd       = bus.in_rd;
    assign bus2.in_reg_we   = bus.in_reg_we;
    assign bus2.mem_rvalid  = bus.mem_rvalid;
    assign bus2.mem_rdata   = bus.mem_rdata;

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference result: chosen source, or the loaded byte/word computed arithmetically.
    function automatic logic [15:0] model_result(input vec_t v);
        int b;
        if (v.sel == 2'd0) return v.alu;
        if (v.sel == 2'd2) return v.link;
        if (v.sel == 2'd3) return v.imm;
        if (v.size == 2'd1 || v.size == 2'd2) begin
            b = (int'(v.mem) >> (8 * int'(v.off))) % 256;
            if (v.size == 2'd1 && b >= 128) b = b + 65536 - 256;
            return 16'(b);
        end
        return v.mem;
    endfunction

    function automatic vec_t mk(input logic [1:0] sel, input logic [1:0] size, input logic off,
                                input logic [15:0] val, input logic [2:0] rd, input logic we,
                                input logic [15:0] exp);
        vec_t v;
        v.sel = sel; v.size = size; v.off = off;
        v.alu = 16'h0; v.link = 16'h0; v.imm = 16'h0; v.mem = 16'h0;
        case (sel)
            2'd0: v.alu = val;
            2'd1: v.mem = val;
            2'd2: v.link = val;
            default: v.imm = val;
        endcase
        v.rd = rd; v.we = we; v.exp = exp;
        return v;
    endfunction

    // driver tasks
    task automatic drive_op(input vec_t v);
        bus.in_wb_sel   = v.sel;
        bus.in_ld_size  = v.size;
        bus.in_byte_off = v.off;
        bus.in_alu      = v.alu;
        bus.in_link     = v.link;
        bus.in_imm      = v.imm;
        bus.in_rd       = v.rd;
        bus.in_reg_we   = v.we;
        bus.in_valid    = 1'b1;
    endtask

    // Called just after a rising edge with the stage ready; returns just after the edge into COMMIT.
    task automatic issue(input vec_t v, input int d);
        drive_op(v);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (v.sel == 2'd1) begin
            for (int k = 0; k <= d; k++) begin
                if (k == d) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = v.mem;
                end else begin
                    bus.in_valid  = 1'($urandom_range(0, 1));
                    bus.in_wb_sel = 2'($urandom_range(0, 3));
                    bus.in_alu    = 16'($urandom);
                    bus.in_rd     = 3'($urandom_range(0, 7));
                    bus.mem_rdata = 16'($urandom);
                end
                @(negedge clk);
                check("wait_in_ready", 32'(bus.in_ready), 0);
                check("wait_pend_valid", 32'(bus.pend_valid), 32'(v.we));
                if (v.we) check("wait_pend_rd", 32'(bus.pend_rd), 32'(v.rd));
                @(posedge clk); #1;
            end
            bus.mem_rvalid = 1'b0;
            bus.in_valid   = 1'b0;
        end
    endtask

    // scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (sb_en && rst_n && bus.rf_we) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_rf_we", 32'(bus.rf_we), 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_waddr", 32'(bus.rf_waddr), 32'(e[18:16]));
                check("sb_wdata", 32'(bus.rf_wdata), 32'(e[15:0]));
            end
        end
    end

    initial begin
        vec_t vecs[12];
        vec_t v;
        vec_t b2b[4];
        int d;
        int gap;

        bus.in_valid = 1'b0; bus.in_wb_sel = 2'd0; bus.in_ld_size = 2'd0; bus.in_byte_off = 1'b0;
        bus.in_alu = 16'h0; bus.in_link = 16'h0; bus.in_imm = 16'h0; bus.in_rd = 3'd0;
        bus.in_reg_we = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 16'h0;

        vecs[0]  = mk(2'd0, 2'd0, 1'b0, 16'h1234, 3'd3, 1'b1, 16'h1234);
        vecs[1]  = mk(2'd1, 2'd0, 1'b0, 16'hBEEF, 3'd5, 1'b1, 16'hBEEF);
        vecs[2]  = mk(2'd1, 2'd1, 1'b0, 16'h80F0, 3'd1, 1'b1, 16'hFFF0);
        vecs[3]  = mk(2'd1, 2'd1, 1'b1, 16'h80F0, 3'd2, 1'b1, 16'hFF80);
        vecs[4]  = mk(2'd1, 2'd2, 1'b1, 16'h80F0, 3'd4, 1'b1, 16'h0080);
        vecs[5]  = mk(2'd1, 2'd2, 1'b0, 16'h80F0, 3'd6, 1'b1, 16'h00F0);
        vecs[6]  = mk(2'd1, 2'd3, 1'b1, 16'h80F0, 3'd7, 1'b1, 16'h80F0);
        vecs[7]  = mk(2'd2, 2'd0, 1'b0, 16'h0102, 3'd2, 1'b1, 16'h0102);
        vecs[8]  = mk(2'd3, 2'd0, 1'b0, 16'hABCD, 3'd7, 1'b1, 16'hABCD);
        vecs[9]  = mk(2'd1, 2'd1, 1'b0, 16'h1234, 3'd0, 1'b1, 16'h0034);
        vecs[10] = mk(2'd0, 2'd1, 1'b1, 16'h80F0, 3'd1, 1'b1, 16'h80F0);
        vecs[11] = mk(2'd1, 2'd0, 1'b0, 16'h5555, 3'd4, 1'b0, 16'h5555);

        // Reset with in_valid high: it must be ignored.
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_rf_we", 32'(bus.rf_we), 0);
        check("rst_rf_waddr", 32'(bus.rf_waddr), 0);
        check("rst_rf_wdata", 32'(bus.rf_wdata), 0);
        check("rst_pend_valid", 32'(bus.pend_valid), 0);
        check("rst_pend_rd", 32'(bus.pend_rd), 0);
        check("rst_commit_cnt", 32'(bus.commit_cnt), 0);
        check("rst_err", 32'(bus.err_spurious), 0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));

        // Vector table, one op at a time.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            issue(vecs[i], (i == 1) ? 2 : (i % 3));
            @(negedge clk);
            check($sformatf("tbl_rf_we[%0d]", i), 32'(bus.rf_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check($sformatf("tbl_waddr[%0d]", i), 32'(bus.rf_waddr), 32'(vecs[i].rd));
                check($sformatf("tbl_wdata[%0d]", i), 32'(bus.rf_wdata), 32'(vecs[i].exp));
            end
            exp_commits++;
            @(negedge clk);
            check($sformatf("tbl_rf_we_after[%0d]", i), 32'(bus.rf_we), 0);
            check($sformatf("tbl_cnt[%0d]", i), 32'(bus.commit_cnt), 32'(exp_commits));
            check($sformatf("tbl_cnt2[%0d]", i), 32'(bus2.commit_cnt), 32'(exp_commits % 4));
        end

        // Four back-to-back LINK/IMM ops commit on four consecutive cycles.
        for (int k = 0; k < 4; k++) begin
            b2b[k] = mk((k % 2 == 0) ? 2'd2 : 2'd3, 2'd0, 1'b0, 16'(16'h3000 + k * 16'h0111),
                        3'(k + 1), 1'b1, 16'(16'h3000 + k * 16'h0111));
        end
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k < 4) drive_op(b2b[k]);
            else bus.in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("b2b_in_ready[%0d]", k), 32'(bus.in_ready), 1);
            if (k > 0) begin
                check($sformatf("b2b_rf_we[%0d]", k), 32'(bus.rf_we), 1);
                check($sformatf("b2b_waddr[%0d]", k), 32'(bus.rf_waddr), 32'(b2b[k-1].rd));
                check($sformatf("b2b_wdata[%0d]", k), 32'(bus.rf_wdata), 32'(b2b[k-1].exp));
            end
        end
        exp_commits += 4;
        @(negedge clk);
        check("b2b_rf_we_end", 32'(bus.rf_we), 0);
        check("b2b_cnt", 32'(bus.commit_cnt), 32'(exp_commits));

        // Randomized run scored against the model.
        sb_en = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 300; n++) begin
            gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2));
            bus.in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
            v.sel  = 2'($urandom_range(0, 3));
            v.size = 2'($urandom_range(0, 3));
            v.off  = 1'($urandom_range(0, 1));
            v.alu  = 16'($urandom);
            v.link = 16'($urandom);
            v.imm  = 16'($urandom);
            v.mem  = 16'($urandom);
            v.rd   = 3'($urandom_range(0, 7));
            v.we   = ($urandom_range(0, 3) != 0);
            v.exp  = model_result(v);
            if (v.we) exp_q.push_back({v.rd, v.exp});
            exp_commits++;
            d = int'($urandom_range(0, 3));
            issue(v, d);
        end
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        sb_en = 1'b0;
        check("rand_queue_drained", 32'(exp_q.size()), 0);
        check("rand_cnt", 32'(bus.commit_cnt), 32'(exp_commits % 65536));
        check("rand_cnt2", 32'(bus2.commit_cnt), 32'(exp_commits % 4));
        check("rand_no_err", 32'(bus.err_spurious), 0);

        // Spurious read data in IDLE: sticky error, no write, no commit.
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'h1111;
        @(negedge clk);
        check("spur_rf_we", 32'(bus.rf_we), 0);
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        check("spur_err", 32'(bus.err_spurious), 1);
        check("spur_rf_we_next", 32'(bus.rf_we), 0);
        check("spur_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        repeat (3) @(negedge clk);
        check("spur_err_sticky", 32'(bus.err_spurious), 1);
        check("spur_cnt", 32'(bus.commit_cnt), 32'(exp_commits % 65536));

        // Reset while a load is pending.
        @(posedge clk); #1;
        drive_op(mk(2'd1, 2'd0, 1'b0, 16'h7777, 3'd5, 1'b1, 16'h7777));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mrst_pend_valid", 32'(bus.pend_valid), 1);
        check("mrst_pend_rd", 32'(bus.pend_rd), 5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive_op(mk(2'd0, 2'd0, 1'b0, 16'h4242, 3'd6, 1'b1, 16'h4242));
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'h7777;
        @(negedge clk);
        check("mrst_rf_we", 32'(bus.rf_we), 0);
        check("mrst_rf_waddr", 32'(bus.rf_waddr), 0);
        check("mrst_rf_wdata", 32'(bus.rf_wdata), 0);
        check("mrst_pend_valid0", 32'(bus.pend_valid), 0);
        check("mrst_pend_rd0", 32'(bus.pend_rd), 0);
        check("mrst_cnt", 32'(bus.commit_cnt), 0);
        check("mrst_cnt2", 32'(bus2.commit_cnt), 0);
        check("mrst_err", 32'(bus.err_spurious), 0);
        check("mrst_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.mem_rvalid = 1'b0;
        rst_n = 1'b1;
        exp_commits = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_rf_we[%0d]", k), 32'(bus.rf_we), 0);
            check($sformatf("post_rst_state[%0d]", k), 32'(bus.dbg_state), 32'(ST_IDLE));
        end
        @(posedge clk); #1;
        issue(mk(2'd3, 2'd0, 1'b0, 16'h0F0F, 3'd6, 1'b1, 16'h0F0F), 0);
        @(negedge clk);
        check("post_rst_op_we", 32'(bus.rf_we), 1);
        check("post_rst_op_wdata", 32'(bus.rf_wdata), 32'(16'h0F0F));
        @(negedge clk);
        check("post_rst_cnt", 32'(bus.commit_cnt), 1);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
